tick_divider_bank: RTL and testbench

Parametrised bank of NCH independent programmable tick generators for the digital clock and related designs. Each channel divides clk by a runtime-writable divisor and emits a one-cycle tick and a 50%-duty square wave. Uses include the 1 Hz seconds tick, display scan ticks and blink rates. Divisor updates are glitch-free: they take effect only at a period boundary.

---
 rtl/tick_divider_bank.sv | 171 +++++++++++++++++
 tb/tb_tick_divider_bank.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/tick_divider_bank.sv
// -----------------------------------------------------------------------------
// tick_divider_bank
//   A bank of NCH independent programmable tick generators. Each channel divides
//   clk by a runtime-writable divisor. Every period it emits a one-cycle tick and
//   toggles a square wave. A new divisor is held in a shadow register and only
//   becomes active at a period boundary, so periods are never cut short.
//
// Ports
//   clk       in   system clock
//   clr_n     in   asynchronous active-low reset
//   sync_clr  in   synchronous restart of all channels (loads shadow divisors)
//   en        in   [NCH]  per-channel count enable
//   wr_en     in   divisor write strobe
//   wr_ch     in   [WCH]  channel index for the write (>= NCH is ignored)
//   wr_div    in   [CW]   new divisor value (0 behaves as 1)
//   tick      out  [NCH]  registered one-cycle pulse per period
//   sq        out  [NCH]  registered square wave, toggles on every tick
//   pending   out  [NCH]  shadow divisor written but not yet active
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// tick_divider_lane
//   One channel of the bank. All outputs come straight from flops.
//
// Ports
//   i_clk, i_rst_n   clock, async active-low reset
//   i_sync_clr       restart: cnt/tick/sq cleared, shadow divisor made active
//   i_en             count enable
//   i_wr             write strobe already decoded for this lane
//   i_wr_div         divisor being written
//   o_tick           one-cycle pulse at each wrap
//   o_sq             toggles at each wrap
//   o_pending        shadow divisor waiting for the next wrap
// -----------------------------------------------------------------------------
module tick_divider_lane #(
   parameter int unsigned     CW      = 32,
   parameter logic [CW-1:0]   DEF_DIV = CW'(5)
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_sync_clr,
   input  logic          i_en,
   input  logic          i_wr,
   input  logic [CW-1:0] i_wr_div,
   output logic          o_tick,
   output logic          o_sq,
   output logic          o_pending
);

   logic [CW-1:0] r_cnt;
   logic [CW-1:0] r_act;
   logic [CW-1:0] r_shd;
   logic          r_tick;
   logic          r_sq;
   logic          r_pend;

   logic [CW-1:0] w_lim;
   logic          w_wrap;

   // Terminal count is D-1 with D = max(active, 1); a zero divisor therefore
   // yields a limit of 0 and the lane ticks on every enabled edge.
   assign w_lim  = (r_act == '0) ? '0 : (r_act - CW'(1));
   // ">=" rather than "==": a count left above a freshly shrunk divisor still
   // wraps on the next enabled edge instead of running all the way round.
   assign w_wrap = i_en && (r_cnt >= w_lim);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt  <= '0;
         r_act  <= DEF_DIV;
         r_shd  <= DEF_DIV;
         r_tick <= 1'b0;
         r_sq   <= 1'b0;
         r_pend <= 1'b0;
      end else if (i_sync_clr) begin
         // Restart: a same-cycle write wins over the stored shadow value.
         r_cnt  <= '0;
         r_tick <= 1'b0;
         r_sq   <= 1'b0;
         r_pend <= 1'b0;
         if (i_wr) begin
            r_act <= i_wr_div;
            r_shd <= i_wr_div;
         end else begin
            r_act <= r_shd;
         end
      end else if (i_wr && !i_en) begin
         // Idle lane: no period in flight, so the divisor can switch now.
         r_act  <= i_wr_div;
         r_shd  <= i_wr_div;
         r_cnt  <= '0;
         r_pend <= 1'b0;
         r_tick <= 1'b0;
      end else if (w_wrap) begin
         r_cnt  <= '0;
         r_tick <= 1'b1;
         r_sq   <= ~r_sq;
         r_pend <= 1'b0;
         if (i_wr) begin
            // Write landing on the boundary starts the new period directly.
            r_act <= i_wr_div;
            r_shd <= i_wr_div;
         end else if (r_pend) begin
            r_act <= r_shd;
         end
      end else if (i_en) begin
         r_cnt  <= r_cnt + CW'(1);
         r_tick <= 1'b0;
         if (i_wr) begin
            r_shd  <= i_wr_div;
            r_pend <= 1'b1;
         end
      end else begin
         r_tick <= 1'b0;
      end
   end

   assign o_tick    = r_tick;
   assign o_sq      = r_sq;
   assign o_pending = r_pend;

endmodule

module tick_divider_bank #(
   parameter int unsigned NCH     = 4,
   parameter int unsigned CW      = 32,
   parameter int unsigned DEF_DIV = 100_000_000,
   localparam int unsigned WCH    = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic            clk,
   input  logic            clr_n,
   input  logic            sync_clr,
   input  logic [NCH-1:0]  en,
   input  logic            wr_en,
   input  logic [WCH-1:0]  wr_ch,
   input  logic [CW-1:0]   wr_div,
   output logic [NCH-1:0]  tick,
   output logic [NCH-1:0]  sq,
   output logic [NCH-1:0]  pending
);

   localparam logic [CW-1:0] W_DEF = CW'(DEF_DIV);

   logic [NCH-1:0] w_wr_sel;

   // One-hot write decode; an index >= NCH selects no lane, so it is dropped.
   always_comb begin
      w_wr_sel = '0;
      for (int i = 0; i < NCH; i++) begin
         w_wr_sel[i] = wr_en && (int'(wr_ch) == i);
      end
   end

   for (genvar g = 0; g < NCH; g++) begin : g_lane
      tick_divider_lane #(
         .CW      (CW),
         .DEF_DIV (W_DEF)
      ) u_lane (
         .i_clk      (clk),
         .i_rst_n    (clr_n),
         .i_sync_clr (sync_clr),
         .i_en       (en[g]),
         .i_wr       (w_wr_sel[g]),
         .i_wr_div   (wr_div),
         .o_tick     (tick[g]),
         .o_sq       (sq[g]),
         .o_pending  (pending[g])
      );
   end

endmodule

// File: tb/tb_tick_divider_bank.sv
// -----------------------------------------------------------------------------
// tb_tick_divider_bank
//   Directed stimulus for a 4-channel bank (DEF_DIV=5) with an event-level
//   model of each channel checked every cycle, plus hand-computed literal
//   expectations. A 3-channel instance covers out-of-range write indexes,
//   which a 2-bit wr_ch on a 4-channel bank cannot express.
// -----------------------------------------------------------------------------
module tb_tick_divider_bank;

   localparam int NCH = 4;
   localparam int CW  = 8;
   localparam int DEF = 5;
   localparam int WCH = 2;

   logic           clk      = 1'b0;
   logic           clr_n    = 1'b0;
   logic           sync_clr = 1'b0;
   logic [NCH-1:0] en       = '0;
   logic           wr_en    = 1'b0;
   logic [WCH-1:0] wr_ch    = '0;
   logic [CW-1:0]  wr_div   = '0;
   wire  [NCH-1:0] tick, sq, pending;

   logic           b_clr_n  = 1'b0;
   logic [2:0]     b_en     = '0;
   logic           b_wr_en  = 1'b0;
   logic [1:0]     b_wr_ch  = '0;
   logic [CW-1:0]  b_wr_div = '0;
   wire  [2:0]     b_tick, b_sq, b_pend;

   int nvec = 0;
   int nmis = 0;

   always #5 clk = ~clk;

   tick_divider_bank #(.NCH(NCH), .CW(CW), .DEF_DIV(DEF)) dut (
      .clk(clk), .clr_n(clr_n), .sync_clr(sync_clr), .en(en),
      .wr_en(wr_en), .wr_ch(wr_ch), .wr_div(wr_div),
      .tick(tick), .sq(sq), .pending(pending)
   );

   tick_divider_bank #(.NCH(3), .CW(CW), .DEF_DIV(DEF)) dut3 (
      .clk(clk), .clr_n(b_clr_n), .sync_clr(1'b0), .en(b_en),
      .wr_en(b_wr_en), .wr_ch(b_wr_ch), .wr_div(b_wr_div),
      .tick(b_tick), .sq(b_sq), .pending(b_pend)
   );

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Model: each channel knows its period length, how many enabled edges of
   // the current period have elapsed, and a staged divisor for the next one.
   longint m_per[NCH], m_shd[NCH], m_ph[NCH];
   bit     m_pend[NCH], m_tick[NCH], m_sq[NCH];

   always @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         for (int c = 0; c < NCH; c++) begin
            m_per[c] <= DEF; m_shd[c] <= DEF; m_ph[c] <= 0;
            m_pend[c] <= 0;  m_tick[c] <= 0;  m_sq[c] <= 0;
         end
      end else begin
         for (int c = 0; c < NCH; c++) begin
            automatic bit     hit = wr_en && (int'(wr_ch) == c);
            automatic longint eff = (m_per[c] == 0) ? 1 : m_per[c];
            if (sync_clr) begin
               m_ph[c] <= 0; m_tick[c] <= 0; m_sq[c] <= 0; m_pend[c] <= 0;
               m_per[c] <= hit ? longint'(wr_div) : m_shd[c];
               if (hit) m_shd[c] <= longint'(wr_div);
            end else if (hit && !en[c]) begin
               m_per[c] <= longint'(wr_div); m_shd[c] <= longint'(wr_div);
               m_ph[c] <= 0; m_pend[c] <= 0; m_tick[c] <= 0;
            end else if (en[c]) begin
               if (m_ph[c] + 1 >= eff) begin
                  // this edge completes the period
                  m_tick[c] <= 1; m_sq[c] <= !m_sq[c]; m_ph[c] <= 0; m_pend[c] <= 0;
                  if (hit) begin
                     m_per[c] <= longint'(wr_div); m_shd[c] <= longint'(wr_div);
                  end else if (m_pend[c]) begin
                     m_per[c] <= m_shd[c];
                  end
               end else begin
                  m_tick[c] <= 0; m_ph[c] <= m_ph[c] + 1;
                  if (hit) begin
                     m_shd[c] <= longint'(wr_div); m_pend[c] <= 1;
                  end
               end
            end else begin
               m_tick[c] <= 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (clr_n) begin
         logic [NCH-1:0] et, es, ep;
         for (int c = 0; c < NCH; c++) begin
            et[c] = m_tick[c]; es[c] = m_sq[c]; ep[c] = m_pend[c];
         end
         chk("model_tick", 8'(tick), 8'(et));
         chk("model_sq", 8'(sq), 8'(es));
         chk("model_pending", 8'(pending), 8'(ep));
      end
   end

   initial begin
      en = 4'b0001;
      step(2);
      chk("rst_tick", 8'(tick), 8'h00);
      chk("rst_sq", 8'(sq), 8'h00);
      chk("rst_pend", 8'(pending), 8'h00);

      // 1: ch0 alone, D=5 -> ticks at edges 5 and 10
      clr_n = 1'b1;
      step(4); chk("t1_e4_tick", 8'(tick), 8'b0000);
      step(1); chk("t1_e5_tick", 8'(tick), 8'b0001); chk("t1_e5_sq", 8'(sq), 8'b0001);
      step(1); chk("t1_e6_tick", 8'(tick), 8'b0000);
      step(4); chk("t1_e10_tick", 8'(tick), 8'b0001); chk("t1_e10_sq", 8'(sq), 8'b0000);

      // 2: hold en[0] low for 3 cycles at cnt=2 -> next tick at edge 18
      step(2); en = 4'b0000;
      step(3); chk("t2_hold_tick", 8'(tick), 8'b0000); chk("t2_hold_sq", 8'(sq), 8'b0000);
      en = 4'b0001;
      step(2); chk("t2_e17_tick", 8'(tick), 8'b0000);
      step(1); chk("t2_e18_tick", 8'(tick), 8'b0001); chk("t2_e18_sq", 8'(sq), 8'b0001);

      // 3: ch1 write 3 at cnt=1, period still ends at 5
      en = 4'b0011;
      step(1);
      wr_en = 1'b1; wr_ch = 2'd1; wr_div = 8'd3;
      step(1); wr_en = 1'b0;
      chk("t3_pend_set", 8'(pending), 8'b0010);
      step(2); chk("t3_e22_tick", 8'(tick), 8'b0000); chk("t3_e22_pend", 8'(pending), 8'b0010);
      step(1); chk("t3_e23_tick", 8'(tick), 8'b0011); chk("t3_e23_pend", 8'(pending), 8'b0000);
      step(2); chk("t3_e25_tick", 8'(tick), 8'b0000);
      step(1); chk("t3_e26_tick", 8'(tick), 8'b0010);
      step(2); chk("t3_e28_tick", 8'(tick), 8'b0001);
      // write 4 on ch1's wrap edge (edge 29): applies at once, no pending
      wr_en = 1'b1; wr_ch = 2'd1; wr_div = 8'd4;
      step(1); wr_en = 1'b0;
      chk("t3_e29_tick", 8'(tick), 8'b0010); chk("t3_e29_pend", 8'(pending), 8'b0000);
      step(3); chk("t3_e32_tick", 8'(tick), 8'b0000);
      step(1); chk("t3_e33_tick", 8'(tick), 8'b0011); chk("t3_e33_pend", 8'(pending), 8'b0000);

      // 4: divisor 0 then 1 on disabled ch2 -> tick every cycle
      wr_en = 1'b1; wr_ch = 2'd2; wr_div = 8'd0;
      step(1); wr_en = 1'b0;
      chk("t4_pend", 8'(pending), 8'b0000);
      en = 4'b0111;
      step(1); chk("t4_d0_tick2", 8'(tick[2]), 8'd1); chk("t4_d0_sq2", 8'(sq[2]), 8'd1);
      step(1); chk("t4_d0_tick2b", 8'(tick[2]), 8'd1); chk("t4_d0_sq2b", 8'(sq[2]), 8'd0);
      en = 4'b0011; wr_en = 1'b1; wr_ch = 2'd2; wr_div = 8'd1;
      step(1); wr_en = 1'b0; en = 4'b0111;
      step(1); chk("t4_d1_tick2", 8'(tick[2]), 8'd1); chk("t4_d1_sq2", 8'(sq[2]), 8'd1);
      step(1); chk("t4_d1_tick2b", 8'(tick[2]), 8'd1); chk("t4_d1_sq2b", 8'(sq[2]), 8'd0);

      // 5: pend a write on ch1, then sync_clr with a same-cycle write to ch3
      wr_en = 1'b1; wr_ch = 2'd1; wr_div = 8'd2;
      step(1); wr_en = 1'b0;
      chk("t5_pend1", 8'(pending), 8'b0010);
      sync_clr = 1'b1; wr_en = 1'b1; wr_ch = 2'd3; wr_div = 8'd7; en = 4'b1111;
      step(1); sync_clr = 1'b0; wr_en = 1'b0;
      chk("t5_clr_tick", 8'(tick), 8'b0000);
      chk("t5_clr_sq", 8'(sq), 8'b0000);
      chk("t5_clr_pend", 8'(pending), 8'b0000);
      step(6); chk("t5_e6_tick3", 8'(tick[3]), 8'd0);
      step(1); chk("t5_e7_tick3", 8'(tick[3]), 8'd1);
      step(7); chk("t5_e14_tick3", 8'(tick[3]), 8'd1);

      // 6: async reset between edges clears outputs without a clock
      wr_en = 1'b1; wr_ch = 2'd3; wr_div = 8'd6;
      step(1); wr_en = 1'b0;
      chk("t6_pend3", 8'(pending), 8'b1000);
      chk("t6_pre_tick2", 8'(tick[2]), 8'd1);
      @(posedge clk); #2;
      clr_n = 1'b0;
      #1;
      chk("t6_async_tick", 8'(tick), 8'b0000);
      chk("t6_async_sq", 8'(sq), 8'b0000);
      chk("t6_async_pend", 8'(pending), 8'b0000);
      step(1); clr_n = 1'b1;
      step(4); chk("t6_e4_tick", 8'(tick), 8'b0000);
      step(1); chk("t6_e5_tick", 8'(tick), 8'b1111); chk("t6_e5_sq", 8'(sq), 8'b1111);

      // out-of-range write index on a 3-channel bank is dropped
      b_en = 3'b111; b_clr_n = 1'b1;
      step(1);
      b_wr_en = 1'b1; b_wr_ch = 2'd3; b_wr_div = 8'd2;
      step(1); b_wr_en = 1'b0;
      chk("oor_pend", 8'(b_pend), 8'b000);
      step(2); chk("oor_e4_tick", 8'(b_tick), 8'b000);
      step(1); chk("oor_e5_tick", 8'(b_tick), 8'b111);
      step(4); chk("oor_e9_tick", 8'(b_tick), 8'b000);
      step(1); chk("oor_e10_tick", 8'(b_tick), 8'b111);
      chk("oor_e10_sq", 8'(b_sq), 8'b000);
      chk("oor_e10_pend", 8'(b_pend), 8'b000);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
